// File: rtl/seq_divider_pkg.sv
// Shared CPU constants for the multi-cycle divider and the control unit that waits on it.
package seq_divider_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int DIV_COUNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RUN   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: quotient to lo, remainder to hi, with divide-by-zero flag.
// Signed operands are divided as magnitudes and the signs are restored in FIX.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_r;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic             signed_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic             neg_q_r;
  logic             neg_rem_r;
  logic [CNT_W-1:0] count_r;

  logic [WIDTH:0]   shifted_s;
  logic             take_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quo_next_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    logic [WIDTH-1:0] r;
    if (en) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // One restoring shift-subtract step; the remainder stays below the divisor, so the
  // subtraction result always fits back into WIDTH bits when it is taken.
  always_comb begin
    shifted_s  = {rem_r, quo_r[WIDTH-1]};
    take_s     = (shifted_s >= {1'b0, dvs_r});
    diff_s     = shifted_s[WIDTH-1:0] - dvs_r;
    quo_next_s = {quo_r[WIDTH-2:0], take_s};
    if (take_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
  end

  // Control FSM and datapath registers, including all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      signed_r   <= 1'b0;
      quo_r      <= '0;
      rem_r      <= '0;
      dvs_r      <= '0;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      count_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            dividend_r <= dividend;
            divisor_r  <= divisor;
            signed_r   <= signed_op;
            busy       <= 1'b1;
            state_r    <= CHECK;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        CHECK: begin
          if (divisor_r == '0) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= 1'b1;
            state_r  <= DONE;
          end else begin
            quo_r     <= cond_neg(dividend_r, signed_r && dividend_r[WIDTH-1]);
            dvs_r     <= cond_neg(divisor_r, signed_r && divisor_r[WIDTH-1]);
            rem_r     <= '0;
            count_r   <= '0;
            neg_q_r   <= signed_r && (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
            neg_rem_r <= signed_r && dividend_r[WIDTH-1];
            state_r   <= RUN;
          end
        end
        RUN: begin
          rem_r   <= rem_next_s;
          quo_r   <= quo_next_s;
          count_r <= count_r + CNT_W'(1);
          if (count_r == CNT_W'(WIDTH - 1)) begin
            state_r <= FIX;
          end else begin
            state_r <= RUN;
          end
        end
        FIX: begin
          lo       <= cond_neg(quo_r, neg_q_r);
          hi       <= cond_neg(rem_r, neg_rem_r);
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= 1'b0;
          state_r  <= DONE;
        end
        DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: expected results come from native 64-bit division
// pushed to a scoreboard at launch and popped when done is seen.
module tb_seq_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] model_lo = '0;
  logic [W-1:0] model_hi = '0;

  always #5 clock = ~clock;

  seq_divider #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .signed_op(signed_op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference result; a zero divisor leaves the previous hi/lo in place.
  task automatic push_expected(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint num;
    longint den;
    if (b == 32'h0) begin
      e.lo = model_lo;
      e.hi = model_hi;
      e.dz = 1'b1;
    end else begin
      if (s) begin
        num = longint'($signed(a));
        den = longint'($signed(b));
      end else begin
        num = longint'({32'h0, a});
        den = longint'({32'h0, b});
      end
      e.lo = W'(num / den);
      e.hi = W'(num % den);
      e.dz = 1'b0;
      model_lo = e.lo;
      model_hi = e.hi;
    end
    sb_q.push_back(e);
  endtask

  // Drive start for one edge (edge k), then scramble the operands.
  task automatic launch(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    push_expected(s, a, b);
    @(posedge clock);
    #1;
    start     = 1'b0;
    dividend  = ~a;
    divisor   = b ^ 32'h0000_0005;
    signed_op = ~s;
  endtask

  // mode 1 also pulses start during RUN and during the DONE cycle.
  task automatic wait_result(input string tag, input int mode);
    int   n;
    bit   seen;
    bit   busy_ok;
    exp_t e;
    int   lat_exp;
    n       = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    e       = sb_q.pop_front();
    lat_exp = e.dz ? 2 : 35;
    while (!seen && n < 60) begin
      @(negedge clock);
      n++;
      if (mode == 1 && n == 10) begin
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
      end else if (mode == 1 && n == 11) begin
        start = 1'b0;
      end
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, " latency"}, W'(n), W'(lat_exp));
    check({tag, " busy_before_done"}, {31'h0, busy_ok}, 32'h1);
    check({tag, " busy_at_done"}, {31'h0, busy}, 32'h0);
    check({tag, " lo"}, lo, e.lo);
    check({tag, " hi"}, hi, e.hi);
    check({tag, " div_zero"}, {31'h0, div_zero}, {31'h0, e.dz});
    if (mode == 1) begin
      start    = 1'b1;
      dividend = 32'd9;
      divisor  = 32'd4;
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  initial begin
    int extra_done;
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset div_zero", {31'h0, div_zero}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b0;

    launch(1'b1, 32'd100, 32'd7);
    wait_result("s100/7", 0);
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);           // -100 / 7
    wait_result("s-100/7", 0);
    launch(1'b1, 32'd100, 32'hFFFF_FFF9);         // 100 / -7
    wait_result("s100/-7", 0);
    launch(1'b0, 32'hFFFF_FFFF, 32'd2);
    wait_result("uFFFFFFFF/2", 0);
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("s_overflow", 0);
    launch(1'b0, 32'hDEAD_BEEF, 32'h0001_0000);
    wait_result("u_big", 0);

    launch(1'b1, 32'd100, 32'd7);
    wait_result("s100/7_again", 0);
    launch(1'b1, 32'd500, 32'd0);
    wait_result("div_by_zero", 0);

    launch(1'b0, 32'd1000, 32'd10);
    wait_result("ignored_starts", 1);
    extra_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) extra_done++;
    end
    check("extra done pulses", W'(extra_done), 32'h0);
    check("hold lo", lo, model_lo);
    check("hold hi", hi, model_hi);

    // Abort in the 10th RUN cycle: no result is produced for this launch.
    launch(1'b0, 32'd123456, 32'd789);
    sb_q.delete();
    repeat (11) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    model_lo = 32'h0;
    model_hi = 32'h0;
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort done", {31'h0, done}, 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    launch(1'b1, 32'd9, 32'd3);
    wait_result("after_reset 9/3", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle signed divider for the MIPS multi-cycle datapath (`div`/`divu`-class execution). It sits directly downstream of the A/B operand registers and feeds the HI/LO source muxes: quotient goes to LO, remainder to HI. The control unit starts it with a one-cycle `start` and waits for `done`. It reports divide-by-zero so the control unit can raise the exception path.

## Interface
- `WIDTH`, 32, operand/result width; `ITERS` is fixed equal to `WIDTH`.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; takes effect on the next rising edge of `clock`.
- `start` in 1: request a division; sampled only in IDLE.
- `signed_op` in 1: 1 selects signed (`div`), 0 selects unsigned (`divu`); latched with `start`.
- `dividend` in WIDTH: operand from register A; latched with `start`.
- `divisor` in WIDTH: operand from register B; latched with `start`.
- `busy` out 1: high in CHECK, RUN and FIX.
- `done` out 1: one-cycle pulse in DONE.
- `div_zero` out 1: high only together with `done` when the latched divisor was 0.
- `hi` out WIDTH: remainder.
- `lo` out WIDTH: quotient.

## Operation
- States:
  - IDLE → CHECK when `start`=1. Operands and `signed_op` latched on that edge.
  - CHECK:
    - divisor==0 → DONE with `div_zero`=1; `hi`/`lo` unchanged.
    - otherwise → RUN. Magnitudes are taken (signed mode only), remainder accumulator is cleared, `count`=0.
  - RUN: one restoring shift-subtract step per cycle, over WIDTH+1-bit remainder arithmetic. At `count`==WIDTH-1 → FIX.
  - FIX:
    - Quotient is negated if signed and the operand signs differ.
    - Remainder is negated if signed and the dividend was negative.
    - Results are written to `hi`/`lo`; → DONE.
  - DONE → IDLE unconditionally.
- Sign rules: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives `lo`=0x80000000, `hi`=0, `div_zero`=0. This is the natural result of unsigned-magnitude arithmetic and needs no special case.
- `start` is ignored in every state except IDLE, including DONE. No queuing.
- Operand changes after the latch edge have no effect.
- `hi`/`lo` hold their value until the next non-zero-divisor completion.
- Reset values: state IDLE; `busy`, `done`, `div_zero` = 0; `hi`, `lo`, internal registers = 0.
- Reset asserted in any state: aborts the operation and applies the reset values at that edge, with no partial write.

## Timing
- `start` is sampled at edge k.
- Normal path:
  - CHECK occupies k..k+1.
  - RUN occupies edges k+2..k+33 (32 iterations).
  - FIX is entered at edge k+33.
  - The edge k+34 writes `hi`/`lo` and enters DONE.
  - `done`=1 for the cycle between k+34 and k+35.
  - Latency from `start` to `done` is 35 cycles.
- Divide-by-zero path: `done`=`div_zero`=1 for the cycle between edges k+1 and k+2.
- Back-to-back: the earliest next accepted `start` is at edge k+36 (normal) or k+3 (zero divisor).
- `hi`/`lo` are valid from the `done` cycle onward.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared CPU package holds:
  - state enum (IDLE, CHECK, RUN, FIX, DONE);
  - `DATA_WIDTH`=32;
  - `DIV_COUNT_W`=$clog2(32)=5.
- The control unit reuses these constants for its wait state.
- No sub-module: one FSM plus the datapath (magnitude/negate logic, WIDTH+1-bit subtractor, quotient/remainder shift registers, 5-bit counter) in a single module.

## Test plan
- Signed 100 / 7, `start` at edge k → `done` between k+34 and k+35; `lo`=14, `hi`=2; `busy` high k..k+34.
- Signed -100 / 7 → `lo`=0xFFFFFFF2 (-14), `hi`=0xFFFFFFFE (-2). Signed 100 / -7 → `lo`=-14, `hi`=2.
- Unsigned 0xFFFFFFFF / 2 → `lo`=0x7FFFFFFF, `hi`=1. Signed 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- Divisor 0 after a prior 100/7 → `done`=`div_zero`=1 two cycles after `start`; `hi`=2, `lo`=14 retained.
- `start` pulsed during RUN and again during DONE → ignored; the single result is unchanged and exactly one `done` pulse occurs.
- `reset` at the 10th RUN cycle → next edge: IDLE, `busy`=0, `hi`=`lo`=0; a subsequent 9/3 then gives `lo`=3, `hi`=0 with normal latency.
